truth_table_sequencer: RTL

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/truth_table_sequencer.sv
// Sweeps a 4-input function under test through vectors 0..15, waits a
// programmable settle time per vector, captures its output and compares it to a golden table.
module truth_table_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  settle,
  input  logic [15:0] expected,
  output logic [3:0]  fut_in,
  input  logic        fut_s,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatches,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [3:0]  wait_cnt, wait_nx;
  logic [3:0]  settle_q, settle_nx;
  logic [3:0]  fut_in_nx;
  logic [15:0] expected_q, expected_nx;
  logic [15:0] table_nx;
  logic [4:0]  mm_nx;
  logic        pass_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      settle_q    <= '0;
      expected_q  <= '0;
      fut_in      <= '0;
      truth_table <= '0;
      mismatches  <= '0;
      pass        <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      wait_cnt    <= wait_nx;
      settle_q    <= settle_nx;
      expected_q  <= expected_nx;
      fut_in      <= fut_in_nx;
      truth_table <= table_nx;
      mismatches  <= mm_nx;
      pass        <= pass_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    wait_nx     = wait_cnt;
    settle_nx   = settle_q;
    expected_nx = expected_q;
    fut_in_nx   = fut_in;
    table_nx    = truth_table;
    mm_nx       = mismatches;
    pass_nx     = pass;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nx      = '0;
          fut_in_nx   = '0;
          settle_nx   = settle;
          expected_nx = expected;
          table_nx    = '0;
          mm_nx       = '0;
          wait_nx     = settle;
          state_nx    = SETTLE;
        end
      end
      SETTLE: begin
        if (wait_cnt == '0) state_nx = SAMPLE;
        else                wait_nx  = wait_cnt - 4'd1;
      end
      SAMPLE: begin
        table_nx[idx] = fut_s;
        // At most 16 increments per sweep, so 5 bits never wrap.
        if (fut_s != expected_q[idx]) mm_nx = mismatches + 5'd1;
        if (idx == 4'd15) begin
          pass_nx  = (mm_nx == '0);
          state_nx = DONE;
        end else begin
          idx_nx    = idx + 4'd1;
          fut_in_nx = idx + 4'd1;
          wait_nx   = settle_q;
          state_nx  = SETTLE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

endmodule
